// File: rtl/wb_gpio_if.sv
// Wishbone B3 classic bus bundle between the SoC initiator and the GPIO responder.
// The master modport faces the initiator and the slave modport faces wb_gpio_slave.
interface wb_gpio_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [31:0]           wdata;
    logic [3:0]            sel;
    logic                  we;
    logic                  cyc;
    logic                  stb;
    logic [31:0]           rdata;
    logic                  ack;

    modport master (
        output adr, wdata, sel, we, cyc, stb,
        input  rdata, ack
    );

    modport slave (
        input  adr, wdata, sel, we, cyc, stb,
        output rdata, ack
    );
endinterface

// File: rtl/wb_gpio_slave.sv
// Wishbone B3 classic GPIO bank: OUT/DIR/SET/CLR registers and a 2-flop input synchronizer.
// Define WB_GPIO_IRQ_EN to add edge-triggered interrupt registers (MASK/STATUS/EDGE) and irq_o.
module wb_gpio_slave #(
    parameter int GPIO_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    wb_gpio_if.slave              wb,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    typedef enum logic [2:0] {
        REG_IN     = 3'd0,
        REG_OUT    = 3'd1,
        REG_DIR    = 3'd2,
        REG_SET    = 3'd3,
        REG_CLR    = 3'd4,
        REG_MASK   = 3'd5,
        REG_STATUS = 3'd6,
        REG_EDGE   = 3'd7
    } reg_e;

    logic                  req;
    logic [31:0]           rd_word;
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
    logic [GPIO_WIDTH-1:0] out_q, dir_q;
    logic                  wr_q;
    reg_e                  wreg_q;
    logic [GPIO_WIDTH-1:0] wd_q, wm_q;
    logic                  unused_bits;

`ifdef WB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev_q, mask_q, status_q, edge_q, edge_hit;
    logic                  irq_q;
`endif

    // Only the GPIO_WIDTH low bits, their byte lanes and the word address are consumed.
    assign unused_bits = ^{wb.adr[1:0], wb.wdata, wb.sel};

    function automatic logic [GPIO_WIDTH-1:0] lane_gate(input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < GPIO_WIDTH; i++) lane_gate[i] = d[i] & s[i / 8];
    endfunction

    function automatic logic [31:0] widen(input logic [GPIO_WIDTH-1:0] v);
        widen = '0;
        widen[GPIO_WIDTH-1:0] = v;
    endfunction

    // Anything at or above byte offset 0x20 is unmapped.
    function automatic logic in_map(input logic [ADDR_WIDTH-1:0] a);
        in_map = ((a >> 5) == '0);
    endfunction

    // A new request is taken only when no ack is outstanding, giving ack,idle,ack on a held strobe.
    assign req = wb.cyc & wb.stb & ~wb.ack;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (in_map(wb.adr)) begin
            case (reg_e'(wb.adr[4:2]))
                REG_IN:     rd_word = widen(sync2_q);
                REG_OUT:    rd_word = widen(out_q);
                REG_DIR:    rd_word = widen(dir_q);
`ifdef WB_GPIO_IRQ_EN
                REG_MASK:   rd_word = widen(mask_q);
                REG_STATUS: rd_word = widen(status_q);
                REG_EDGE:   rd_word = widen(edge_q);
`endif
                default:    rd_word = '0;
            endcase
        end
    end

    // NOTE: asynchronous active-low reset; all state, including write-capture flops, returns to 0.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb.ack   <= 1'b0;
            wb.rdata <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            wr_q     <= 1'b0;
            wreg_q   <= REG_IN;
            wd_q     <= '0;
            wm_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            sync1_q  <= gpio_i;
            sync2_q  <= sync1_q;
            wb.ack   <= req;
            wb.rdata <= (req && !wb.we) ? rd_word : '0;

            // Write is captured at request time so it still commits if cyc drops during the ack cycle.
            wr_q <= req & wb.we & in_map(wb.adr);
            if (req) begin
                wreg_q <= reg_e'(wb.adr[4:2]);
                wd_q   <= lane_gate(wb.wdata, wb.sel);
                wm_q   <= lane_gate(32'hFFFF_FFFF, wb.sel);
            end

            if (wr_q) begin
                case (wreg_q)
                    REG_OUT: out_q <= (out_q & ~wm_q) | wd_q;
                    REG_DIR: dir_q <= (dir_q & ~wm_q) | wd_q;
                    REG_SET: out_q <= out_q | wd_q;
                    REG_CLR: out_q <= out_q & ~wd_q;
                    default: ;
                endcase
            end
        end
    end

    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;

`ifdef WB_GPIO_IRQ_EN
    assign edge_hit = (edge_q & sync2_q & ~prev_q) | (~edge_q & ~sync2_q & prev_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            prev_q   <= '0;
            mask_q   <= '0;
            status_q <= '0;
            edge_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            if (wr_q && wreg_q == REG_MASK) mask_q <= (mask_q & ~wm_q) | wd_q;
            if (wr_q && wreg_q == REG_EDGE) edge_q <= (edge_q & ~wm_q) | wd_q;
            // OR-ing the edge in after the clear lets a coincident edge win over W1C.
            status_q <= (status_q & ~((wr_q && wreg_q == REG_STATUS) ? wd_q : '0)) | edge_hit;
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Directed self-checking bench for wb_gpio_slave (GPIO_WIDTH=8, ADDR_WIDTH=8 so 0x40 is unmapped).
module tb_wb_gpio_slave;
    localparam int GW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GW-1:0] gpio_i = '0;
    logic [GW-1:0] gpio_o, gpio_dir_o;
    logic          irq_o;
    int            total = 0;
    int            bad = 0;

    wb_gpio_if #(.ADDR_WIDTH(AW)) wb();

    wb_gpio_slave #(.GPIO_WIDTH(GW), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb.slave),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One classic transfer: drive after a falling edge, wait (bounded) for ack, sample, release.
    task automatic wb_xfer(input logic [AW-1:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clk);
        wb.adr = a; wb.we = we; wb.wdata = d; wb.sel = s; wb.cyc = 1'b1; wb.stb = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.ack && n < 8);
        check("ack", {31'd0, wb.ack}, 32'd1);
        r = wb.rdata;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(a, 1'b1, d, s, r);
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, r);
        check(tag, r, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic prev_ack;
        logic consecutive;

        wb.adr = '0; wb.wdata = '0; wb.sel = '0; wb.we = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, wb.ack}, 32'd0);
        check("rst_rdata", wb.rdata, 32'd0);
        check("rst_gpio_o", {24'd0, gpio_o}, 32'd0);
        check("rst_dir", {24'd0, gpio_dir_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) rd_check("rst_read", AW'(i * 4), 32'd0);

        // OUT/DIR/SET/CLR
        wb_write(8'h04, 32'h0000_00A5, 4'b0001);
        wb_write(8'h08, 32'h0000_00FF, 4'b1111);
        wb_write(8'h0C, 32'h0000_0002, 4'b1111);
        wb_write(8'h10, 32'h0000_0080, 4'b1111);
        @(negedge clk);
        check("gpio_o_27", {24'd0, gpio_o}, 32'h27);
        check("dir_ff", {24'd0, gpio_dir_o}, 32'hFF);
        rd_check("rd_out", 8'h04, 32'h27);
        rd_check("rd_dir", 8'h08, 32'hFF);
        rd_check("rd_set", 8'h0C, 32'h0);
        rd_check("rd_clr", 8'h10, 32'h0);

        // Byte lanes and bits above GPIO_WIDTH
        wb_write(8'h04, 32'h0000_1234, 4'b0010);
        rd_check("lane1_ignored", 8'h04, 32'h27);
        wb_write(8'h04, 32'h0000_00FF, 4'b0000);
        rd_check("no_lane", 8'h04, 32'h27);
        wb_write(8'h04, 32'hFFFF_FF5C, 4'b1111);
        rd_check("upper_zero", 8'h04, 32'h5C);
        wb_write(8'h04, 32'h0000_0027, 4'b0001);

        // Input synchronizer latency
        @(negedge clk);
        gpio_i = 8'h5A;
        rd_check("in_early", 8'h00, 32'h00);
        rd_check("in_late", 8'h00, 32'h5A);

        // Unmapped
        rd_check("unmapped_40", 8'h40, 32'h0);
        rd_check("unmapped_24", 8'h24, 32'h0);
        wb_write(8'h44, 32'h0000_00FF, 4'b1111);
        rd_check("unmapped_no_alias", 8'h04, 32'h27);

`ifdef WB_GPIO_IRQ_EN
        wb_write(8'h1C, 32'h01, 4'b0001);
        wb_write(8'h14, 32'h01, 4'b0001);
        rd_check("edge_rd", 8'h1C, 32'h01);
        rd_check("mask_rd", 8'h14, 32'h01);
        rd_check("status_idle", 8'h18, 32'h00);
        @(negedge clk);
        gpio_i = 8'h5B;
        repeat (3) @(negedge clk);
        check("irq_not_yet", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        rd_check("status_set", 8'h18, 32'h01);
        wb_write(8'h18, 32'h01, 4'b0001);
        repeat (2) @(negedge clk);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        rd_check("status_clr", 8'h18, 32'h00);

        // W1C commits on the same edge the new rising edge is recorded
        gpio_i = 8'h5A;
        repeat (5) @(negedge clk);
        gpio_i = 8'h5B;
        wb_write(8'h18, 32'h01, 4'b0001);
        rd_check("set_wins", 8'h18, 32'h01);
        wb_write(8'h18, 32'h01, 4'b0001);
        wb_write(8'h14, 32'h00, 4'b0001);
`else
        wb_write(8'h14, 32'hFF, 4'b1111);
        wb_write(8'h1C, 32'hFF, 4'b1111);
        rd_check("mask_absent", 8'h14, 32'h0);
        rd_check("edge_absent", 8'h1C, 32'h0);
        gpio_i = 8'h00;
        repeat (4) @(negedge clk);
        rd_check("status_absent", 8'h18, 32'h0);
        check("irq_tied", {31'd0, irq_o}, 32'd0);
`endif

        // Held strobe: ack,idle,ack...
        @(negedge clk);
        wb.adr = 8'h04; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        acks = 0; prev_ack = 1'b0; consecutive = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb.ack) begin
                acks++;
                check("held_rdata", wb.rdata, 32'h27);
            end else begin
                check("idle_rdata", wb.rdata, 32'h0);
            end
            if (wb.ack && prev_ack) consecutive = 1'b1;
            prev_ack = wb.ack;
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
        check("held_ack_count", acks, 3);
        check("held_no_back_to_back", {31'd0, consecutive}, 32'd0);

        // cyc dropped in the ack cycle still commits the write
        @(negedge clk);
        @(negedge clk);
        wb.adr = 8'h08; wb.we = 1'b1; wb.wdata = 32'h3C; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(negedge clk);
        check("drop_ack", {31'd0, wb.ack}, 32'd1);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        @(negedge clk);
        check("drop_commit", {24'd0, gpio_dir_o}, 32'h3C);

        // Reset asserted during the ack cycle of a write
        @(negedge clk);
        wb.adr = 8'h04; wb.we = 1'b1; wb.wdata = 32'hFF; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(negedge clk);
        check("pre_rst_ack", {31'd0, wb.ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_ack", {31'd0, wb.ack}, 32'd0);
        check("rst_gpio_o", {24'd0, gpio_o}, 32'h0);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_commit", {24'd0, gpio_o}, 32'h0);
        rd_check("rst_out_rd", 8'h04, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
